// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder slice.
// Optional feature macro used elsewhere in this slice: DM_ACCESS_CNT_EN.
package dm_pkg;

  localparam int DATA_BITS = 32;
  localparam logic [3:0] WEB_READ = 4'b1111;

  typedef enum logic [1:0] {
    DM_IDLE,
    DM_BUSY
  } dm_state_e;

  // Any cleared active-low lane enable turns the request into a write.
  function automatic logic dm_is_write(input logic [3:0] web);
    return web != WEB_READ;
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// CPU data-memory port bundle between the MEM stage (master) and the responder (slave).
interface dm_responder_if;
  import dm_pkg::*;

  logic                 cs;
  logic [3:0]           web;
  logic [31:0]          addr;
  logic [DATA_BITS-1:0] din;
  logic                 ready;
  logic [DATA_BITS-1:0] dout;
  logic                 dout_valid;

  modport master (output cs, output web, output addr, output din,
                  input ready, input dout, input dout_valid);

  modport slave (input cs, input web, input addr, input din,
                 output ready, output dout, output dout_valid);

endinterface

// File: rtl/dm_sram_array.sv
// Word-organised byte-lane SRAM with active-low lane write enables and a
// registered write-first read port; the read register only updates on re.
module dm_sram_array
  import dm_pkg::*;
#(
  parameter int DEPTH = 16384,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_W-1:0]     idx,
  input  logic [3:0]           we_n,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 re,
  output logic [DATA_BITS-1:0] q
);

  logic [3:0][7:0]       mem [DEPTH];
  logic [DATA_BITS-1:0]  merged;

  always_comb begin
    merged = '0;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = !we_n[i] ? wdata[8*i +: 8] : mem[idx][i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!we_n[i]) mem[idx][i] <= wdata[8*i +: 8];
    end
  end

  // The storage itself is never cleared; only the read register resets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else if (re) q <= merged;
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: accepts MEM-stage requests, commits byte-lane writes and
// returns read words after READ_LAT cycles. DM_ACCESS_CNT_EN adds rd_cnt/wr_cnt.
module dm_responder
  import dm_pkg::*;
#(
  parameter int DEPTH    = 16384,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  dm_responder_if.slave bus
`ifdef DM_ACCESS_CNT_EN
  ,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(READ_LAT - 1);

  dm_state_e        state, next_state;
  logic [3:0]       cnt, next_cnt;
  logic [IDX_W-1:0] lat_idx, req_idx, sram_idx;
  logic [3:0]       sram_we_n;
  logic             accept, rd_accept, wr_accept, complete;
  logic             unused_addr;

  assign req_idx     = bus.addr[IDX_W+1:2];
  assign unused_addr = ^{bus.addr[31:IDX_W+2], bus.addr[1:0]};
  assign bus.ready   = (state == DM_IDLE);

  // The final countdown edge loads the read register and returns to IDLE, so
  // ready is already high during the valid pulse.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    complete   = 1'b0;
    sram_idx   = req_idx;
    sram_we_n  = WEB_READ;
    accept     = bus.cs && bus.ready;
    wr_accept  = accept && dm_is_write(bus.web);
    rd_accept  = accept && !dm_is_write(bus.web);
    if (wr_accept) sram_we_n = bus.web;
    case (state)
      DM_IDLE: begin
        if (rd_accept) begin
          next_cnt = CNT_LOAD;
          if (READ_LAT == 1) complete = 1'b1;
          else next_state = DM_BUSY;
        end
      end
      DM_BUSY: begin
        sram_idx = lat_idx;
        next_cnt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          complete   = 1'b1;
          next_state = DM_IDLE;
        end
      end
      default: next_state = DM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= DM_IDLE;
      cnt            <= '0;
      lat_idx        <= '0;
      bus.dout_valid <= 1'b0;
    end else begin
      state          <= next_state;
      cnt            <= next_cnt;
      bus.dout_valid <= complete;
      if (rd_accept) lat_idx <= req_idx;
    end
  end

`ifdef DM_ACCESS_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (rd_accept) rd_cnt <= rd_cnt + 32'd1;
      if (wr_accept) wr_cnt <= wr_cnt + 32'd1;
    end
  end
`endif

  dm_sram_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .idx   (sram_idx),
    .we_n  (sram_we_n),
    .wdata (bus.din),
    .re    (complete),
    .q     (bus.dout)
  );

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: a single-cycle instance driven from a vector
// table and a 3-cycle, 16-word instance for latency, wrap, abort and counters.
module tb_dm_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  dm_responder_if if1();
  dm_responder_if if3();

`ifdef DM_ACCESS_CNT_EN
  logic [31:0] rd_cnt1, wr_cnt1, rd_cnt3, wr_cnt3;
`endif

  dm_responder #(.DEPTH(16384), .READ_LAT(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
`ifdef DM_ACCESS_CNT_EN
    ,
    .rd_cnt (rd_cnt1),
    .wr_cnt (wr_cnt1)
`endif
  );

  dm_responder #(.DEPTH(16), .READ_LAT(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3.slave)
`ifdef DM_ACCESS_CNT_EN
    ,
    .rd_cnt (rd_cnt3),
    .wr_cnt (wr_cnt3)
`endif
  );

  typedef struct {
    logic [3:0]  web;
    logic [31:0] addr;
    logic [31:0] din;
    logic        exp_valid;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one request on the single-cycle port and waits until its effect is visible.
  task automatic applyStimulus(input logic [3:0] web, input logic [31:0] addr, input logic [31:0] din);
    if1.cs   = 1'b1;
    if1.web  = web;
    if1.addr = addr;
    if1.din  = din;
    @(negedge clk);
  endtask

  task automatic write3(input logic [3:0] web, input logic [31:0] addr, input logic [31:0] din);
    if3.cs = 1'b1; if3.web = web; if3.addr = addr; if3.din = din;
    @(negedge clk);
    if3.cs = 1'b0;
    checkOutput("w3_ready", 32'(if3.ready), 32'd1);
    checkOutput("w3_valid", 32'(if3.dout_valid), 32'd0);
  endtask

  task automatic read3(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    if3.cs = 1'b1; if3.web = 4'b1111; if3.addr = addr; if3.din = '0;
    @(negedge clk);
    if3.cs = 1'b0;
    checkOutput({tag, "_busy1_ready"}, 32'(if3.ready), 32'd0);
    checkOutput({tag, "_busy1_valid"}, 32'(if3.dout_valid), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_busy2_ready"}, 32'(if3.ready), 32'd0);
    checkOutput({tag, "_busy2_valid"}, 32'(if3.dout_valid), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_valid"}, 32'(if3.dout_valid), 32'd1);
    checkOutput({tag, "_dout"}, if3.dout, exp);
    checkOutput({tag, "_ready"}, 32'(if3.ready), 32'd1);
  endtask

  initial begin
    vecs[0]  = '{4'b0000, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    vecs[1]  = '{4'b1111, 32'h0000_0100, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{4'b0000, 32'h0000_0040, 32'h1122_3344, 1'b0, 32'hDEAD_BEEF};
    vecs[3]  = '{4'b1101, 32'h0000_0040, 32'h0000_AA00, 1'b0, 32'hDEAD_BEEF};
    vecs[4]  = '{4'b1111, 32'h0000_0040, 32'h0,         1'b1, 32'h1122_AA44};
    vecs[5]  = '{4'b0011, 32'h0000_0040, 32'h5566_0000, 1'b0, 32'h1122_AA44};
    vecs[6]  = '{4'b1111, 32'h0000_0040, 32'h0,         1'b1, 32'h5566_AA44};
    vecs[7]  = '{4'b0000, 32'h0000_0200, 32'h1234_5678, 1'b0, 32'h5566_AA44};
    vecs[8]  = '{4'b1110, 32'h0000_0200, 32'h0000_00CD, 1'b0, 32'h5566_AA44};
    vecs[9]  = '{4'b1111, 32'h0000_0203, 32'h0,         1'b1, 32'h1234_56CD};
    vecs[10] = '{4'b0000, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0, 32'h1234_56CD};
    vecs[11] = '{4'b1111, 32'h0001_0000, 32'h0,         1'b1, 32'hA5A5_A5A5};
    vecs[12] = '{4'b1111, 32'hFFFF_0100, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[13] = '{4'b1111, 32'h0000_0100, 32'h0,         1'b1, 32'hDEAD_BEEF};

    if1.cs = 1'b0; if1.web = 4'b1111; if1.addr = '0; if1.din = '0;
    if3.cs = 1'b0; if3.web = 4'b1111; if3.addr = '0; if3.din = '0;
    repeat (2) @(negedge clk);
    checkOutput("por_ready1", 32'(if1.ready), 32'd1);
    checkOutput("por_valid1", 32'(if1.dout_valid), 32'd0);
    checkOutput("por_dout1", if1.dout, 32'd0);
    checkOutput("por_ready3", 32'(if3.ready), 32'd1);
    rst = 1'b0;

    // Back-to-back requests, one per cycle, on the single-cycle instance.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].web, vecs[i].addr, vecs[i].din);
      checkOutput($sformatf("vec%0d_valid", i), 32'(if1.dout_valid), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("vec%0d_dout", i), if1.dout, vecs[i].exp_dout);
      checkOutput($sformatf("vec%0d_ready", i), 32'(if1.ready), 32'd1);
    end
    if1.cs = 1'b0;

    // Asynchronous reset between clock edges while a valid pulse is showing.
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_ready1", 32'(if1.ready), 32'd1);
    checkOutput("arst_dout1", if1.dout, 32'd0);
    checkOutput("arst_valid1", 32'(if1.dout_valid), 32'd0);
    checkOutput("arst_dout3", if3.dout, 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    applyStimulus(4'b1111, 32'h0000_0100, 32'h0);
    if1.cs = 1'b0;
    checkOutput("kept_after_rst", if1.dout, 32'hDEAD_BEEF);

    // DEPTH=16: byte address 0x40 aliases word 0.
    write3(4'b0000, 32'h0000_0040, 32'h0000_0077);
    write3(4'b0000, 32'h0000_0004, 32'h0000_0099);
    read3(32'h0000_0000, 32'h0000_0077, "wrap");

    // A held cs during BUSY is taken only once ready returns.
    if3.cs = 1'b1; if3.web = 4'b1111; if3.addr = 32'h0000_0000;
    @(negedge clk);
    if3.addr = 32'h0000_0004;
    checkOutput("bp_ready_a", 32'(if3.ready), 32'd0);
    @(negedge clk);
    checkOutput("bp_ready_b", 32'(if3.ready), 32'd0);
    checkOutput("bp_valid_b", 32'(if3.dout_valid), 32'd0);
    @(negedge clk);
    checkOutput("bp_valid_first", 32'(if3.dout_valid), 32'd1);
    checkOutput("bp_dout_first", if3.dout, 32'h0000_0077);
    checkOutput("bp_ready_first", 32'(if3.ready), 32'd1);
    @(negedge clk);
    if3.cs = 1'b0;
    checkOutput("bp_ready_second", 32'(if3.ready), 32'd0);
    checkOutput("bp_valid_second", 32'(if3.dout_valid), 32'd0);
    checkOutput("bp_dout_held", if3.dout, 32'h0000_0077);
    @(negedge clk);
    checkOutput("bp_valid_gap", 32'(if3.dout_valid), 32'd0);
    @(negedge clk);
    checkOutput("bp_valid_last", 32'(if3.dout_valid), 32'd1);
    checkOutput("bp_dout_last", if3.dout, 32'h0000_0099);

    // Reset in the middle of a 3-cycle read aborts it without touching the array.
    write3(4'b0000, 32'h0000_0008, 32'hCAFE_F00D);
    if3.cs = 1'b1; if3.web = 4'b1111; if3.addr = 32'h0000_0008;
    @(negedge clk);
    if3.cs = 1'b0;
    checkOutput("abort_busy", 32'(if3.ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    checkOutput("abort_ready", 32'(if3.ready), 32'd1);
    checkOutput("abort_valid", 32'(if3.dout_valid), 32'd0);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("abort_novalid%0d", k), 32'(if3.dout_valid), 32'd0);
    end
    read3(32'h0000_0008, 32'hCAFE_F00D, "reread8");
    read3(32'h0000_0000, 32'h0000_0077, "reread0");

`ifdef DM_ACCESS_CNT_EN
    @(negedge clk);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("cnt_rd_rst", rd_cnt3, 32'd0);
    checkOutput("cnt_wr_rst", wr_cnt3, 32'd0);
    for (int k = 0; k < 5; k++) write3(4'b0000, 32'(16 + 4*k), 32'(k));
    read3(32'h0000_0010, 32'h0000_0000, "cnt_rd");
    if3.cs = 1'b1; if3.web = 4'b1111; if3.addr = 32'h0000_0014;
    @(negedge clk);
    if3.addr = 32'h0000_0018;
    repeat (3) @(negedge clk);
    if3.cs = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("cnt_dout", if3.dout, 32'h0000_0002);
    checkOutput("cnt_wr", wr_cnt3, 32'd5);
    checkOutput("cnt_rd", rd_cnt3, 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
